// File: rtl/atmo_light_est.sv
// Per-frame atmospheric-light estimator: tracks the brightest dark-channel pixel of each frame
// and blends its RGB into the A registers once per frame end.
module atmo_light_est #(
   parameter int DATA_WIDTH   = 8,
   parameter int IMG_WIDTH    = 320,
   parameter int IMG_HEIGHT   = 240,
   parameter int SMOOTH_SHIFT = 3,
   parameter int A_MIN        = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] dark_in,
   input  logic [DATA_WIDTH-1:0] r_in,
   input  logic [DATA_WIDTH-1:0] g_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic [DATA_WIDTH-1:0] a_r,
   output logic [DATA_WIDTH-1:0] a_g,
   output logic [DATA_WIDTH-1:0] a_b,
   output logic                  a_valid,
   output logic [15:0]           frame_cnt
);

   localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [XW-1:0]         X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0]         Y_LAST = YW'(IMG_HEIGHT - 1);
   localparam logic [DATA_WIDTH-1:0] AMIN_C = DATA_WIDTH'(A_MIN);

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_UPD = 1'b1
   } state_t;

   state_t                state_r;
   logic [XW-1:0]         x_r;
   logic [YW-1:0]         y_r;
   logic [DATA_WIDTH-1:0] max_dark_r, max_r_r, max_g_r, max_b_r;
   logic [DATA_WIDTH-1:0] cand_r_r, cand_g_r, cand_b_r;
   logic                  first_frame_r;

   logic                  first_pix_s, last_pix_s, take_s;
   logic [DATA_WIDTH-1:0] sel_r_s, sel_g_s, sel_b_s;
   logic [DATA_WIDTH-1:0] upd_r_s, upd_g_s, upd_b_s;

   // IIR step in a signed DATA_WIDTH+1 difference; the result always lies between A and cand,
   // so truncating back to DATA_WIDTH bits cannot overflow.
   function automatic logic [DATA_WIDTH-1:0] smooth_f(
      input logic [DATA_WIDTH-1:0] cand,
      input logic [DATA_WIDTH-1:0] acc,
      input logic                  first
   );
      logic signed [DATA_WIDTH:0]   diff;
      logic signed [DATA_WIDTH:0]   step;
      logic signed [DATA_WIDTH+1:0] sum;
      logic [DATA_WIDTH-1:0]        res;
      diff = $signed({1'b0, cand}) - $signed({1'b0, acc});
      step = diff >>> SMOOTH_SHIFT;
      sum  = $signed({2'b00, acc}) + $signed({step[DATA_WIDTH], step});
      if (first) begin
         res = cand;
      end else begin
         res = sum[DATA_WIDTH-1:0];
      end
      if (res < AMIN_C) begin
         res = AMIN_C;
      end else begin
         res = res;
      end
      return res;
   endfunction

   // Pixel position decode and max-tracker selection, including the current pixel
   always_comb begin
      first_pix_s = (x_r == '0) && (y_r == '0);
      last_pix_s  = valid_in && (x_r == X_LAST) && (y_r == Y_LAST);
      take_s      = valid_in && (first_pix_s || (dark_in > max_dark_r));
      if (take_s) begin
         sel_r_s = r_in;
         sel_g_s = g_in;
         sel_b_s = b_in;
      end else begin
         sel_r_s = max_r_r;
         sel_g_s = max_g_r;
         sel_b_s = max_b_r;
      end
   end

   assign upd_r_s = smooth_f(cand_r_r, a_r, first_frame_r);
   assign upd_g_s = smooth_f(cand_g_r, a_g, first_frame_r);
   assign upd_b_s = smooth_f(cand_b_r, a_b, first_frame_r);

   // Raster position counters, frozen during input gaps
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r <= '0;
         y_r <= '0;
      end else if (valid_in) begin
         if (x_r == X_LAST) begin
            x_r <= '0;
            y_r <= (y_r == Y_LAST) ? '0 : y_r + 1'b1;
         end else begin
            x_r <= x_r + 1'b1;
         end
      end
   end

   // Max tracker, ACC/UPD sequencing and registered A outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_ACC;
         max_dark_r    <= '0;
         max_r_r       <= '0;
         max_g_r       <= '0;
         max_b_r       <= '0;
         cand_r_r      <= '0;
         cand_g_r      <= '0;
         cand_b_r      <= '0;
         first_frame_r <= 1'b1;
         a_r           <= '1;
         a_g           <= '1;
         a_b           <= '1;
         a_valid       <= 1'b0;
         frame_cnt     <= 16'd0;
      end else begin
         a_valid <= 1'b0;
         if (take_s) begin
            max_dark_r <= dark_in;
            max_r_r    <= r_in;
            max_g_r    <= g_in;
            max_b_r    <= b_in;
         end
         case (state_r)
            ST_ACC: begin
               if (last_pix_s) begin
                  cand_r_r   <= sel_r_s;
                  cand_g_r   <= sel_g_s;
                  cand_b_r   <= sel_b_s;
                  max_dark_r <= '0;
                  state_r    <= ST_UPD;
               end
            end
            ST_UPD: begin
               a_r           <= upd_r_s;
               a_g           <= upd_g_s;
               a_b           <= upd_b_s;
               a_valid       <= 1'b1;
               frame_cnt     <= frame_cnt + 16'd1;
               first_frame_r <= 1'b0;
               state_r       <= ST_ACC;
            end
            default: state_r <= ST_ACC;
         endcase
      end
   end

endmodule
